serial_deserializer: RTL and testbench

- Receive-side counterpart of the team's parallel/serial shift register.
- Collects a serial bit stream, one bit per qualified cycle, into a WIDTH-bit word.
- Presents the finished word on a valid/ready handshake.
- Sits at the far end of any serial link driven by the shift register and supports both shift directions (LSB-first or MSB-first framing).

---
 rtl/serial_deserializer_pkg.sv | 17 +
 rtl/deser_bit_counter.sv | 39 +++
 rtl/serial_deserializer.sv | 134 +++++++++++++
 tb/tb_serial_deserializer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_deserializer_pkg.sv
// Shared types and constants for the serial deserializer.
// Pure declarations, no logic and no latency.
// No backpressure involvement.
package serial_deserializer_pkg;

    // Frame state: waiting for start, collecting bits, or holding a finished word.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Direction latched with start: right shift fills from MSB (LSB-first word).
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/deser_bit_counter.sv
// Bit counter for the deserializer: counts qualified bits, wraps at WIDTH-1.
// Terminal-count flag is combinational from the registered count.
// No backpressure; the parent decides when to enable or clear.
module deser_bit_counter #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0] count_q, count_d;

    assign tc = (count_q == CW'(WIDTH - 1));

    // Clear wins over enable; the last bit of a word returns the count to zero.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = tc ? '0 : count_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/serial_deserializer.sv
// Assembles WIDTH serial bits (LSB- or MSB-first) into a word on a valid/ready output.
// Latency: out_valid rises one cycle after the last bit of the frame.
// While a word is pending, incoming bits are dropped and flag the sticky overrun.
module serial_deserializer
    import serial_deserializer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             rl,
    input  logic             serial_in,
    input  logic             bit_valid,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun
);

    state_t           state_q, state_d;
    logic             rl_q, rl_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             overrun_q, overrun_d;
    logic [WIDTH-1:0] shifted;
    logic             cnt_clr, cnt_en, cnt_tc;

    deser_bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .tc    (cnt_tc)
    );

    // Shift register value after accepting serial_in in the latched direction.
    always_comb begin
        if (rl_q == DIR_RIGHT) begin
            shifted = {serial_in, sr_q[WIDTH-1:1]};
        end else begin
            shifted = {sr_q[WIDTH-2:0], serial_in};
        end
    end

    // Next-state, datapath and handshake decisions.
    always_comb begin
        state_d     = state_q;
        rl_d        = rl_q;
        sr_d        = sr_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rl_d      = rl;
                    sr_d      = '0;
                    cnt_clr   = 1'b1;
                    overrun_d = 1'b0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (start) begin
                    // Restart discards partial bits and re-latches direction.
                    rl_d    = rl;
                    sr_d    = '0;
                    cnt_clr = 1'b1;
                end else if (bit_valid) begin
                    sr_d   = shifted;
                    cnt_en = 1'b1;
                    if (cnt_tc) begin
                        out_d       = shifted;
                        out_valid_d = 1'b1;
                        state_d     = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    if (start) begin
                        rl_d      = rl;
                        sr_d      = '0;
                        cnt_clr   = 1'b1;
                        overrun_d = 1'b0;
                        state_d   = ST_SHIFT;
                    end else begin
                        if (bit_valid) begin
                            overrun_d = 1'b1;
                        end
                        state_d = ST_IDLE;
                    end
                end else if (bit_valid) begin
                    // No room for a new bit while the word waits.
                    overrun_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any partial or pending word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rl_q        <= DIR_LEFT;
            sr_q        <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rl_q        <= rl_d;
            sr_q        <= sr_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_deserializer.sv
// Self-checking bench for serial_deserializer with directed and random frames.
// Outputs are sampled 1 time unit after each rising edge.
// Consumer readiness is varied to exercise hold and overrun behaviour.
module tb_serial_deserializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset, start, rl, serial_in, bit_valid, out_ready;
    logic [W-1:0] out;
    logic         out_valid, busy, overrun;

    int checks = 0;
    int errors = 0;

    serial_deserializer #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rl        (rl),
        .serial_in (serial_in),
        .bit_valid (bit_valid),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Reference: the i-th received bit lands at position i (LSB-first) or W-1-i (MSB-first).
    function automatic logic [W-1:0] model_word(input logic b[W], input logic lsb_first);
        int acc = 0;
        for (int i = 0; i < W; i++) begin
            if (b[i]) acc += lsb_first ? (1 << i) : (1 << (W - 1 - i));
        end
        return acc[W-1:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic b);
        bit_valid = 1'b1;
        serial_in = b;
        step();
        bit_valid = 1'b0;
    endtask

    task automatic begin_frame(input logic dir);
        start = 1'b1;
        rl    = dir;
        step();
        start = 1'b0;
        rl    = ~dir;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; rl = 1'b1; serial_in = 1'b1; bit_valid = 1'b1; out_ready = 1'b1;
        step();
        step();
        reset = 1'b0; start = 1'b0; bit_valid = 1'b0; out_ready = 1'b0;
        checks++; if (out !== 8'h00) begin errors++; $display("FAIL reset_out got %h want 00", out); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
    endtask

    task automatic test_lsb_first();
        logic [7:0] pat = 8'b1011_0010;
        begin_frame(1'b1);
        for (int i = 0; i < W; i++) begin
            feed(pat[7-i]);
            if (i == W - 2) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lsb_early_valid got %b want 0", out_valid); end
            end
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lsb_valid got %b want 1", out_valid); end
        checks++; if (out !== 8'h4D) begin errors++; $display("FAIL lsb_out got %h want 4d", out); end
        step();
        step();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lsb_busy_hold got %b want 1", busy); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lsb_valid_hold got %b want 1", out_valid); end
        handshake();
    endtask

    task automatic test_msb_first();
        logic [7:0] pat = 8'b1011_0010;
        // Bits in IDLE are ignored.
        feed(1'b1);
        feed(1'b0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
        // A bit offered with start is not captured.
        start = 1'b1; rl = 1'b0; bit_valid = 1'b1; serial_in = 1'b1;
        step();
        start = 1'b0; rl = 1'b1; bit_valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            feed(pat[7-i]);
            if (i == W - 2) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL msb_start_bit got %b want 0", out_valid); end
            end
        end
        checks++; if (out !== 8'hB2) begin errors++; $display("FAIL msb_out got %h want b2", out); end
        handshake();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL msb_valid_after got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL msb_busy_after got %b want 0", busy); end
        checks++; if (out !== 8'hB2) begin errors++; $display("FAIL msb_out_kept got %h want b2", out); end
    endtask

    task automatic test_gaps();
        logic [7:0] pat = 8'b1011_0010;
        begin_frame(1'b1);
        for (int i = 0; i < 4; i++) feed(pat[7-i]);
        for (int g = 0; g < 3; g++) begin
            serial_in = 1'($urandom);
            step();
        end
        checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL gap_state got busy=%b valid=%b want 1 0", busy, out_valid); end
        for (int i = 4; i < W; i++) feed(pat[7-i]);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL gap_valid got %b want 1", out_valid); end
        checks++; if (out !== 8'h4D) begin errors++; $display("FAIL gap_out got %h want 4d", out); end
        handshake();
    endtask

    task automatic test_overrun();
        logic [7:0] pat = 8'b1011_0010;
        begin_frame(1'b0);
        for (int i = 0; i < W; i++) feed(pat[7-i]);
        for (int c = 0; c < 5; c++) begin
            bit_valid = (c == 1 || c == 3);
            serial_in = 1'($urandom);
            step();
            bit_valid = 1'b0;
        end
        checks++; if (out !== 8'hB2) begin errors++; $display("FAIL ovr_out got %h want b2", out); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b want 1", out_valid); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b want 1", overrun); end
        out_ready = 1'b1; start = 1'b1; rl = 1'b0;
        step();
        out_ready = 1'b0; start = 1'b0; rl = 1'b1;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b want 0", overrun); end
        checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL ovr_restart got valid=%b busy=%b want 0 1", out_valid, busy); end
    endtask

    // Continues from the SHIFT state left by test_overrun.
    task automatic test_restart();
        for (int i = 0; i < 3; i++) feed(1'b0);
        begin_frame(1'b0);
        for (int i = 0; i < W; i++) begin
            feed(1'b1);
            if (i == W - 2) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL restart_residue got %b want 0", out_valid); end
            end
        end
        checks++; if (out !== 8'hFF || out_valid !== 1'b1) begin errors++; $display("FAIL restart_out got %h/%b want ff/1", out, out_valid); end
        // Bit during a plain handshake is dropped and flagged.
        out_ready = 1'b1; bit_valid = 1'b1; serial_in = 1'b0;
        step();
        out_ready = 1'b0; bit_valid = 1'b0;
        checks++; if (overrun !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL hs_overrun got ovr=%b busy=%b want 1 0", overrun, busy); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] pat = 8'hA5;
        begin_frame(1'b1);
        for (int i = 0; i < 5; i++) feed(1'($urandom));
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (out !== 8'h00 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_out got %h/%b want 00/0", out, out_valid); end
        checks++; if (busy !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL mid_reset_flags got busy=%b ovr=%b want 0 0", busy, overrun); end
        begin_frame(1'b0);
        for (int i = 0; i < W; i++) feed(pat[7-i]);
        checks++; if (out !== 8'hA5 || out_valid !== 1'b1) begin errors++; $display("FAIL after_reset_out got %h/%b want a5/1", out, out_valid); end
        handshake();
    endtask

    task automatic test_random_frames();
        logic         b[W];
        logic         dir;
        logic [W-1:0] exp_word;
        for (int f = 0; f < 25; f++) begin
            dir = 1'($urandom);
            for (int i = 0; i < W; i++) b[i] = 1'($urandom);
            exp_word = model_word(b, dir);
            begin_frame(dir);
            for (int i = 0; i < W; i++) begin
                while ($urandom_range(0, 3) == 0) begin
                    serial_in = 1'($urandom);
                    step();
                end
                feed(b[i]);
            end
            checks++; if (out_valid !== 1'b1 || out !== exp_word) begin errors++; $display("FAIL rand_word[%0d] got %h/%b want %h/1", f, out, out_valid, exp_word); end
            for (int d = 0; d < int'($urandom_range(0, 3)); d++) step();
            checks++; if (out !== exp_word || overrun !== 1'b0) begin errors++; $display("FAIL rand_hold[%0d] got %h ovr=%b want %h ovr=0", f, out, overrun, exp_word); end
            handshake();
            checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rand_hs[%0d] got valid=%b busy=%b want 0 0", f, out_valid, busy); end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; rl = 1'b0; serial_in = 1'b0; bit_valid = 1'b0; out_ready = 1'b0;
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_gaps();
        test_overrun();
        test_restart();
        test_reset_mid_frame();
        test_random_frames();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
